// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage (PC update, imem requests, epoch-tagged in-order instruction FIFO)
// Ports:
//   clk_i, rst_ni                               clock, async active-low reset
//   pc_i / pc_we_o, pc_next_o                   PC register read and write port
//   redirect_i, redirect_pc_i                   redirect from execute
//   imem_req_valid_o/ready_i/addr_o             fetch request channel
//   imem_rsp_valid_i/data_i/err_i               in-order fetch response channel
//   inst_valid_o/ready_i, inst_o/pc_o/fault_o   instruction stream to decode
module ifetch_unit #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] pc_i,
  output logic        pc_we_o,
  output logic [63:0] pc_next_o,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        inst_fault_o
);
  localparam int FAW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int TAW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  logic [63:0]                tag_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_ep;
  logic [TAW-1:0]             tag_rd, tag_wr;
  logic [OCW-1:0]             out_cnt, live;
  logic [31:0]                f_data [FIFO_DEPTH];
  logic [63:0]                f_pc [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]      f_err;
  logic [FAW-1:0]             f_rd, f_wr;
  logic [FCW-1:0]             f_cnt;
  logic epoch, accept, rsp_fire, push, pop;
  // Only requests of the current epoch will land in the FIFO, so only they consume credit.
  always_comb begin
    live = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (i < int'(out_cnt) && tag_ep[tag_rd + TAW'(i)] == epoch) live = live + 1'b1;
  end
  assign imem_req_valid_o = rst_ni & !redirect_i & (int'(out_cnt) < MAX_OUTSTANDING)
                          & (int'(f_cnt) + int'(live) < FIFO_DEPTH);
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o & imem_req_ready_i;
  assign pc_we_o          = rst_ni & (redirect_i | accept);
  assign pc_next_o        = redirect_i ? (redirect_pc_i & ~64'd3) : pc_i + 64'd4;
  // A response with nothing outstanding has no tag to pop and is ignored.
  assign rsp_fire         = imem_rsp_valid_i & (out_cnt != '0);
  assign push             = rsp_fire & (tag_ep[tag_rd] == epoch) & !redirect_i;
  assign inst_valid_o     = rst_ni & (f_cnt != '0) & !redirect_i;
  assign pop              = inst_valid_o & inst_ready_i;
  assign inst_o           = f_data[f_rd];
  assign inst_pc_o        = f_pc[f_rd];
  assign inst_fault_o     = f_err[f_rd];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_rd  <= '0;
      tag_wr  <= '0;
      out_cnt <= '0;
      f_rd    <= '0;
      f_wr    <= '0;
      f_cnt   <= '0;
      epoch   <= 1'b0;
    end else begin
      if (accept) tag_wr <= tag_wr == TAW'(MAX_OUTSTANDING - 1) ? '0 : tag_wr + 1'b1;
      if (rsp_fire) tag_rd <= tag_rd == TAW'(MAX_OUTSTANDING - 1) ? '0 : tag_rd + 1'b1;
      out_cnt <= out_cnt + OCW'(accept) - OCW'(rsp_fire);
      if (redirect_i) begin
        epoch <= ~epoch;
        f_rd  <= '0;
        f_wr  <= '0;
        f_cnt <= '0;
      end else begin
        if (push) f_wr <= f_wr == FAW'(FIFO_DEPTH - 1) ? '0 : f_wr + 1'b1;
        if (pop) f_rd <= f_rd == FAW'(FIFO_DEPTH - 1) ? '0 : f_rd + 1'b1;
        f_cnt <= f_cnt + FCW'(push) - FCW'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_pc[tag_wr] <= pc_i;
      tag_ep[tag_wr] <= epoch;
    end
    if (push) begin
      f_data[f_wr] <= imem_rsp_data_i;
      f_pc[f_wr]   <= tag_pc[tag_rd];
      f_err[f_wr]  <= imem_rsp_err_i;
    end
  end
  a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> out_cnt != '0)
    else $warning("ifetch_unit: imem response with nothing outstanding ignored");
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit
module tb_ifetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] pc_i = '0;
  logic        pc_we_o;
  logic [63:0] pc_next_o;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_fault_o;
  int tests = 0;
  int fails = 0;
  ifetch_unit #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .pc_we_o(pc_we_o), .pc_next_o(pc_next_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    pc_i = 64'h8000_0000;
    imem_req_ready_i = 1'b1;
    #1;
    tests++; if (imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid_o); end
    tests++; if (pc_we_o !== 1'b0) begin fails++; $display("FAIL reset_pc_we got %0b exp 0", pc_we_o); end
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_inst_valid got %0b exp 0", inst_valid_o); end
    step();
    step();
    rst_ni = 1'b1;
  endtask
  task automatic test_basic();
    pc_i = 64'h8000_0000;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b0;
    #1;
    tests++; if (imem_req_valid_o !== 1'b1) begin fails++; $display("FAIL basic_req_valid got %0b exp 1", imem_req_valid_o); end
    tests++; if (imem_req_addr_o !== 64'h8000_0000) begin fails++; $display("FAIL basic_req_addr got %h exp 80000000", imem_req_addr_o); end
    tests++; if (pc_we_o !== 1'b1) begin fails++; $display("FAIL basic_pc_we got %0b exp 1", pc_we_o); end
    tests++; if (pc_next_o !== 64'h8000_0004) begin fails++; $display("FAIL basic_pc_next got %h exp 80000004", pc_next_o); end
    step();
    imem_req_ready_i = 1'b0;
    pc_i = 64'h8000_0004;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0013;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL basic_no_bypass got %0b exp 0", inst_valid_o); end
    tests++; if (pc_we_o !== 1'b0) begin fails++; $display("FAIL basic_pc_we_idle got %0b exp 0", pc_we_o); end
    step();
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL basic_inst_valid got %0b exp 1", inst_valid_o); end
    tests++; if (inst_o !== 32'h13) begin fails++; $display("FAIL basic_inst got %h exp 00000013", inst_o); end
    tests++; if (inst_pc_o !== 64'h8000_0000) begin fails++; $display("FAIL basic_inst_pc got %h exp 80000000", inst_pc_o); end
    tests++; if (inst_fault_o !== 1'b0) begin fails++; $display("FAIL basic_fault got %0b exp 0", inst_fault_o); end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL basic_popped got %0b exp 0", inst_valid_o); end
  endtask
  task automatic test_back_to_back();
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b0;
    pc_i = 64'h8000_0000;
    #1;
    tests++; if (imem_req_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_accept1 got %0b exp 1", imem_req_valid_o); end
    step();
    pc_i = 64'h8000_0004;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0010_0093;
    imem_rsp_err_i = 1'b0;
    #1;
    tests++; if (imem_req_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_accept2 got %0b exp 1", imem_req_valid_o); end
    step();
    pc_i = 64'h8000_0008;
    imem_rsp_data_i = 32'h0020_0113;
    imem_rsp_err_i = 1'b1;
    #1;
    tests++; if (imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_credit_stop got %0b exp 0", imem_req_valid_o); end
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i = 1'b0;
    #1;
    tests++; if (imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_full_stop got %0b exp 0", imem_req_valid_o); end
    tests++; if (inst_o !== 32'h0010_0093) begin fails++; $display("FAIL b2b_head got %h exp 00100093", inst_o); end
    step();
    #1;
    tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || inst_pc_o !== 64'h8000_0000) begin
      fails++; $display("FAIL b2b_hold got v=%0b %h @%h exp v=1 00100093 @80000000", inst_valid_o, inst_o, inst_pc_o);
    end
    imem_req_ready_i = 1'b0;
    inst_ready_i = 1'b1;
    step();
    tests++; if (inst_o !== 32'h0020_0113 || inst_pc_o !== 64'h8000_0004) begin
      fails++; $display("FAIL b2b_second got %h @%h exp 00200113 @80000004", inst_o, inst_pc_o);
    end
    tests++; if (inst_fault_o !== 1'b1) begin fails++; $display("FAIL b2b_fault got %0b exp 1", inst_fault_o); end
    tests++; if (imem_req_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_resume got %0b exp 1", imem_req_valid_o); end
    step();
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_drained got %0b exp 0", inst_valid_o); end
    inst_ready_i = 1'b0;
  endtask
  task automatic test_redirect();
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    pc_i = 64'h8000_0000;
    step();
    pc_i = 64'h8000_0004;
    step();
    imem_req_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    #1;
    tests++; if (pc_we_o !== 1'b1 || pc_next_o !== 64'h8000_0100) begin
      fails++; $display("FAIL redir_pc got we=%0b %h exp we=1 80000100", pc_we_o, pc_next_o);
    end
    tests++; if (imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL redir_no_req got %0b exp 0", imem_req_valid_o); end
    step();
    redirect_i = 1'b0;
    pc_i = 64'h8000_0100;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hdead_beef;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL redir_empty got %0b exp 0", inst_valid_o); end
    step();
    imem_rsp_data_i = 32'h0bad_c0de;
    #1;
    tests++; if (imem_req_valid_o !== 1'b1 || pc_next_o !== 64'h8000_0104) begin
      fails++; $display("FAIL redir_refetch got v=%0b %h exp v=1 80000104", imem_req_valid_o, pc_next_o);
    end
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_data_i = 32'h0000_0513;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL redir_stale_dropped got %0b exp 0", inst_valid_o); end
    inst_ready_i = 1'b0;
    step();
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'h8000_0100 || inst_o !== 32'h0000_0513) begin
      fails++; $display("FAIL redir_target got v=%0b %h @%h exp v=1 00000513 @80000100", inst_valid_o, inst_o, inst_pc_o);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
  endtask
  task automatic test_redirect_collision();
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b0;
    pc_i = 64'h8000_0200;
    step();
    pc_i = 64'h8000_0204;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h1111_1111;
    step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    imem_rsp_data_i = 32'h2222_2222;
    inst_ready_i = 1'b1;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL coll_inst_valid got %0b exp 0", inst_valid_o); end
    tests++; if (pc_we_o !== 1'b1 || pc_next_o !== 64'h8000_0300) begin
      fails++; $display("FAIL coll_pc got we=%0b %h exp we=1 80000300", pc_we_o, pc_next_o);
    end
    step();
    redirect_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL coll_flushed got %0b exp 0", inst_valid_o); end
    tests++; if (imem_req_valid_o !== 1'b1) begin fails++; $display("FAIL coll_credit got %0b exp 1", imem_req_valid_o); end
    inst_ready_i = 1'b0;
  endtask
  task automatic test_pc_boundary();
    pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    imem_req_ready_i = 1'b1;
    #1;
    tests++; if (pc_we_o !== 1'b1 || pc_next_o !== 64'h0) begin
      fails++; $display("FAIL wrap_pc got we=%0b %h exp we=1 0", pc_we_o, pc_next_o);
    end
    step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0102;
    #1;
    tests++; if (pc_we_o !== 1'b1 || pc_next_o !== 64'h8000_0100) begin
      fails++; $display("FAIL align_pc got we=%0b %h exp we=1 80000100", pc_we_o, pc_next_o);
    end
    step();
    redirect_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h3333_3333;
    step();
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1) begin
      fails++; $display("FAIL wrap_drop got inst_v=%0b req_v=%0b exp 0 1", inst_valid_o, imem_req_valid_o);
    end
  endtask
  task automatic test_async_reset();
    pc_i = 64'h8000_0400;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b0;
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0093;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    pc_i = 64'h8000_0404;
    #1;
    tests++; if (imem_req_valid_o !== 1'b1 || inst_valid_o !== 1'b1 || pc_we_o !== 1'b1) begin
      fails++; $display("FAIL arst_pre got req=%0b inst=%0b we=%0b exp 1 1 1", imem_req_valid_o, inst_valid_o, pc_we_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    tests++; if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_we_o !== 1'b0) begin
      fails++; $display("FAIL arst_drop got req=%0b inst=%0b we=%0b exp 0 0 0", imem_req_valid_o, inst_valid_o, pc_we_o);
    end
    imem_req_ready_i = 1'b0;
    step();
    rst_ni = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hdead_beef;
    step();
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1) begin
      fails++; $display("FAIL arst_stray got inst=%0b req=%0b exp 0 1", inst_valid_o, imem_req_valid_o);
    end
    pc_i = 64'h8000_0500;
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_006f;
    step();
    imem_rsp_valid_i = 1'b0;
    #1;
    tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h6f || inst_pc_o !== 64'h8000_0500) begin
      fails++; $display("FAIL arst_after got v=%0b %h @%h exp v=1 0000006f @80000500", inst_valid_o, inst_o, inst_pc_o);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_redirect();
    test_redirect_collision();
    test_pc_boundary();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
